rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_sequencer_if.sv | 20 ++
 rtl/rst_sequencer.sv | 135 +++++++++++++
 tb/tb_rst_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rst_sequencer_if.sv
// Sequencer <-> SDRAM controller / system status bundle.
// The sequencer drives the resets and status; the memory side reports init-done.
interface rst_sequencer_if;
  logic       i_memory_initialized;
  logic       o_sys_rst;
  logic       o_sdr_rst;
  logic       o_sdr_init_req;
  logic       o_system_ready;
  logic       o_init_error;
  logic [2:0] o_state;

  modport master (
    input  i_memory_initialized,
    output o_sys_rst, o_sdr_rst, o_sdr_init_req, o_system_ready, o_init_error, o_state
  );
  modport slave (
    output i_memory_initialized,
    input  o_sys_rst, o_sdr_rst, o_sdr_init_req, o_system_ready, o_init_error, o_state
  );
endinterface

// File: rtl/rst_sequencer.sv
// Board reset sequencer: PLL lock -> settle -> SDRAM power-up -> init (with retry) -> hold -> run.
// Button and PLL lock are synchronized; the button is also debounced.
module rst_sequencer #(
  parameter int unsigned SETTLE_CYCLES   = 256,
  parameter int unsigned PWRUP_CYCLES    = 8000,
  parameter int unsigned INIT_TIMEOUT    = 65535,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic           i_brd_clk,
  input  logic           i_brd_rst,
  input  logic           i_btn_rst,
  input  logic           i_pll_locked,
  rst_sequencer_if.master bus
);

  localparam int unsigned RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [19:0]   SETTLE_END = 20'(SETTLE_CYCLES - 1);
  localparam logic [19:0]   PWRUP_END  = 20'(PWRUP_CYCLES - 1);
  localparam logic [19:0]   INIT_END   = 20'(INIT_TIMEOUT - 1);
  localparam logic [19:0]   HOLD_END   = 20'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DB_END     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    PWRUP     = 3'd2,
    INIT      = 3'd3,
    HOLD      = 3'd4,
    RUN       = 3'd5,
    ERR       = 3'd6
  } state_t;

  state_t        state, nxt;
  logic [19:0]   cnt;
  logic [RW-1:0] retry, retry_inc;
  logic          pll_s1, pll_s2, btn_s1, btn_s2, btn_db;
  logic [DW-1:0] db_cnt;
  logic          tmo, timed;

  assign retry_inc = retry + RW'(1);
  assign timed     = (state == SETTLE) || (state == PWRUP) || (state == INIT) || (state == HOLD);

  // Priority: button, then lock loss, then init-done, then timeout.
  always_comb begin
    nxt = state;
    tmo = 1'b0;
    if (btn_db) begin
      nxt = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: if (pll_s2) nxt = SETTLE;
        SETTLE: begin
          if (!pll_s2)                nxt = WAIT_LOCK;
          else if (cnt == SETTLE_END) nxt = PWRUP;
        end
        PWRUP: begin
          if (!pll_s2)               nxt = WAIT_LOCK;
          else if (cnt == PWRUP_END) nxt = INIT;
        end
        INIT: begin
          if (!pll_s2)                       nxt = WAIT_LOCK;
          else if (bus.i_memory_initialized) nxt = HOLD;
          else if (cnt == INIT_END) begin
            tmo = 1'b1;
            nxt = (retry_inc == RETRY_MAX) ? ERR : SETTLE;
          end
        end
        HOLD: begin
          if (!pll_s2)              nxt = WAIT_LOCK;
          else if (cnt == HOLD_END) nxt = RUN;
        end
        RUN:     if (!pll_s2) nxt = WAIT_LOCK;
        ERR:     nxt = ERR;
        default: nxt = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge i_brd_clk) begin
    if (i_brd_rst) begin
      pll_s1             <= 1'b0;
      pll_s2             <= 1'b0;
      btn_s1             <= 1'b0;
      btn_s2             <= 1'b0;
      btn_db             <= 1'b0;
      db_cnt             <= '0;
      state              <= WAIT_LOCK;
      cnt                <= '0;
      retry              <= '0;
      bus.o_sys_rst      <= 1'b1;
      bus.o_sdr_rst      <= 1'b1;
      bus.o_sdr_init_req <= 1'b0;
      bus.o_system_ready <= 1'b0;
      bus.o_init_error   <= 1'b0;
      bus.o_state        <= 3'd0;
    end else begin
      pll_s1 <= i_pll_locked;
      pll_s2 <= pll_s1;
      btn_s1 <= i_btn_rst;
      btn_s2 <= btn_s1;

      // Count consecutive cycles the synced button disagrees with btn_db.
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_END) begin
        db_cnt <= '0;
        btn_db <= ~btn_db;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end

      state <= nxt;
      if (nxt != state) cnt <= '0;
      else if (timed)   cnt <= cnt + 20'd1;

      if (btn_db)                          retry <= '0;
      else if (nxt == RUN && state != RUN) retry <= '0;
      else if (tmo)                        retry <= retry_inc;

      // Outputs decode the next state so they move with the state register.
      bus.o_sys_rst      <= (nxt != RUN);
      bus.o_sdr_rst      <= (nxt == WAIT_LOCK) || (nxt == SETTLE) || (nxt == ERR);
      bus.o_sdr_init_req <= (nxt == INIT);
      bus.o_system_ready <= (nxt == RUN);
      bus.o_init_error   <= (nxt == ERR);
      bus.o_state        <= nxt;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed + random bench for rst_sequencer against a cycle-level behavioural model.
module tb_rst_sequencer;
  localparam int SET = 4, PWR = 8, ITO = 16, HLD = 2, DEB = 3, MR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, btn = 1'b0, pll = 1'b0, mem = 1'b0;
  int   checks = 0, errors = 0;

  rst_sequencer_if bus();
  assign bus.i_memory_initialized = mem;

  rst_sequencer #(
    .SETTLE_CYCLES(SET), .PWRUP_CYCLES(PWR), .INIT_TIMEOUT(ITO),
    .HOLD_CYCLES(HLD), .DEBOUNCE_CYCLES(DEB), .MAX_RETRY(MR)
  ) dut (
    .i_brd_clk(clk), .i_brd_rst(rst), .i_btn_rst(btn), .i_pll_locked(pll), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: state as a number, time spent in it, attempts used, 2-deep input history, debounce run length.
  int ms = 0, mt = 0, mr = 0, mrun = 0;
  bit p1 = 0, p2 = 0, b1 = 0, b2 = 0, mdb = 0;

  function automatic int next_of();
    if (mdb) return 0;
    if (!p2 && ms >= 1 && ms <= 5) return 0;
    case (ms)
      0: return p2 ? 1 : 0;
      1: return (mt + 1 == SET) ? 2 : 1;
      2: return (mt + 1 == PWR) ? 3 : 2;
      3: begin
        if (mem) return 4;
        if (mt + 1 == ITO) return (mr + 1 == MR) ? 6 : 1;
        return 3;
      end
      4: return (mt + 1 == HLD) ? 5 : 4;
      5: return 5;
      6: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_update();
    int ns;
    if (rst) begin
      ms = 0; mt = 0; mr = 0; mrun = 0;
      p1 = 0; p2 = 0; b1 = 0; b2 = 0; mdb = 0;
      return;
    end
    ns = next_of();
    if (mdb) mr = 0;
    else if (ms == 3 && (ns == 1 || ns == 6)) mr = mr + 1;
    if (ns == 5 && ms != 5) mr = 0;
    mt = (ns != ms) ? 0 : mt + 1;
    ms = ns;
    if (b2 != mdb) begin
      mrun++;
      if (mrun == DEB) begin mdb = ~mdb; mrun = 0; end
    end else mrun = 0;
    p2 = p1; p1 = pll;
    b2 = b1; b1 = btn;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("state",     8'(bus.o_state),        8'(ms));
    chk("sys_rst",   8'(bus.o_sys_rst),      8'(ms != 5));
    chk("sdr_rst",   8'(bus.o_sdr_rst),      8'(ms == 0 || ms == 1 || ms == 6));
    chk("init_req",  8'(bus.o_sdr_init_req), 8'(ms == 3));
    chk("ready",     8'(bus.o_system_ready), 8'(ms == 5));
    chk("init_err",  8'(bus.o_init_error),   8'(ms == 6));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Bounded advance until the model reaches s; the DUT must agree at the end.
  task automatic run_until(input int s, input int budget, input string tag);
    int n = 0;
    while (ms != s && n < budget) begin step(); n++; end
    chk(tag, 8'(bus.o_state), 8'(s));
  endtask

  task automatic to_run();
    run_until(3, 60, "reach_init");
    mem = 1'b1;
    run_until(5, 10, "reach_run");
    mem = 1'b0;
  endtask

  initial begin
    int burst = 0;
    // Reset
    steps(3);
    rst = 1'b0;
    chk("rst_state", 8'(bus.o_state), 8'd0);
    chk("rst_sys",   8'(bus.o_sys_rst), 8'd1);

    // Nominal bring-up: lock, init-done 5 cycles into INIT
    pll = 1'b1;
    steps(3);
    chk("settle_at_3", 8'(bus.o_state), 8'd1);
    run_until(3, 20, "init_entry");
    steps(4);
    mem = 1'b1;
    run_until(5, 10, "nominal_run");
    chk("nominal_ready", 8'(bus.o_system_ready), 8'd1);
    chk("nominal_sysrst", 8'(bus.o_sys_rst), 8'd0);
    mem = 1'b0;

    // Lock loss in RUN, then relock
    pll = 1'b0;
    steps(3);
    chk("lockloss_state", 8'(bus.o_state), 8'd0);
    chk("lockloss_sdr",   8'(bus.o_sdr_rst), 8'd1);
    pll = 1'b1;
    steps(3);
    chk("relock_settle", 8'(bus.o_state), 8'd1);
    to_run();

    // Button glitch, then held button from RUN
    btn = 1'b1; steps(2); btn = 1'b0; steps(8);
    chk("glitch_run", 8'(bus.o_state), 8'd5);
    btn = 1'b1; steps(6);
    chk("btn_from_run", 8'(bus.o_state), 8'd0);
    btn = 1'b0; steps(6);
    to_run();

    // Init never completes: retries exhausted
    rst = 1'b1; step(); rst = 1'b0;
    run_until(6, 200, "err_reached");
    chk("err_flag", 8'(bus.o_init_error), 8'd1);
    pll = 1'b0; steps(5);
    chk("err_ignores_lock", 8'(bus.o_state), 8'd6);
    pll = 1'b1;
    btn = 1'b1; steps(6);
    chk("btn_from_err", 8'(bus.o_state), 8'd0);
    btn = 1'b0; steps(6);

    // Init-done on the timeout cycle wins
    run_until(3, 60, "init_for_tie");
    for (int i = 0; i < 20 && mt != ITO - 1; i++) step();
    mem = 1'b1; step();
    chk("tie_hold", 8'(bus.o_state), 8'd4);
    mem = 1'b0;
    run_until(5, 10, "tie_run");

    // Lock loss and init-done together: lock loss wins
    pll = 1'b0; steps(3); pll = 1'b1;
    run_until(3, 60, "init_for_loss");
    pll = 1'b0; steps(2);
    mem = 1'b1; step();
    chk("loss_beats_done", 8'(bus.o_state), 8'd0);
    mem = 1'b0; pll = 1'b1;

    // Reset pulsed in PWRUP
    run_until(2, 40, "pwrup_for_rst");
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_state", 8'(bus.o_state), 8'd0);
    chk("midrst_sdr",   8'(bus.o_sdr_rst), 8'd1);
    to_run();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if (pll ? ($urandom_range(0, 60) == 0) : ($urandom_range(0, 8) == 0)) pll = ~pll;
      if (burst > 0) burst--;
      else if ($urandom_range(0, 150) == 0) burst = $urandom_range(1, 6);
      btn = (burst > 0);
      mem = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 400) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
